bcd_display_driver: RTL
=======================

// Module: bcd_display_driver
// PURPOSE
//  Output-side counterpart of the push-button decimal entry path. Takes a 14-bit
//  unsigned binary value (entered operand or ALU result) and converts it serially
//  to four BCD digits (shift-add-3, one bit per clock). Encodes the digits into
//  registered 7-segment patterns for ss3..ss0. Sits between the datapath and the
//  board displays in top.
// PARAMETERS
//  WIDTH     14  binary input width; fixes the shift count at WIDTH.
//  NDIG      4   displayed digits; an internal 5th BCD digit detects overflow.
//  BLANK_LZ  1   1 = blank leading zeros (units digit always shown); 0 = show all.
// PORTS
//  clk     in   1      system clock (hz100 in top)
//  rst_n   in   1      asynchronous, active-low reset
//  number  in   WIDTH  binary value to display; sampled only on an accepted start
//  start   in   1      conversion request; single-cycle or level, see BEHAVIOUR
//  busy    out  1      conversion in progress (state != IDLE)
//  done    out  1      one-cycle pulse when ss3..ss0 update
//  ovf     out  1      last converted value > 9999
//  ss3     out  8      thousands segments {dp,g,f,e,d,c,b,a}
//  ss2     out  8      hundreds segments
//  ss1     out  8      tens segments
//  ss0     out  8      units segments
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, ovf=0, ss3..ss0=8'h00 (all blank);
//   shift reg, BCD reg and counter cleared. Async assert; release is sync to clk.
//  FSM IDLE -> SHIFT -> UPDATE -> IDLE.
//   IDLE:   start=1 at an edge -> capture number, clear BCD (20 bits), cnt=0,
//           go SHIFT. Otherwise hold; outputs keep their last value.
//   SHIFT:  each edge: every BCD nibble >=5 gets +3, then {bcd,bin} <<= 1 and
//           cnt++. After WIDTH shifts (cnt==WIDTH-1 on that edge) go UPDATE.
//   UPDATE: register ss3..ss0 and ovf, assert done for this one cycle, go IDLE.
//  Latency: start sampled at edge E0 -> shifts on E1..E14 -> ss/ovf/done
//   registered at E15. busy is high from E0 to E15; done is high for E15..E16.
//  start while busy: ignored, no queueing. A level-held start re-triggers
//   conversion from IDLE (back-to-back is legal; outputs refresh every 16 clk).
//  number changes during SHIFT have no effect (captured copy is used).
//  Overflow: value > 9999 (5th BCD digit != 0) -> ovf=1 and all four ss = 8'h40
//   (dash). Max input 16383 must not wrap inside the BCD register.
//  Encoding (dp=0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F,
//   blank=00, dash=40. Nibbles >9 cannot occur; the decoder maps them to 00.
//  BLANK_LZ=1: a digit is blanked iff it and every higher digit are 0 (ss0 never).
//  Reset mid-SHIFT: aborts, and all outputs return to reset values immediately.
// STRUCTURE
//  Shared package alu_disp_pkg: SEG_BLANK, SEG_DASH, seg digit table
//   (localparam logic [7:0] SEG_DIGIT[10]), and the state enum
//   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} disp_state_t.
//  One sub-module, seg7_digit: combinational 4-bit BCD -> 8-bit segments with a
//   blank input. It is instantiated NDIG times. The FSM, shift-add-3 logic and
//   blanking/ovf logic stay in this module.
// TESTING
//  1. Reset, then number=1234 and a 1-cycle start -> after 15 edges done=1 once;
//     ss3..ss0=06,5B,4F,66; ovf=0.
//  2. number=0, BLANK_LZ=1 -> ss3..ss1=00, ss0=3F. number=0 with BLANK_LZ=0 ->
//     all four=3F. number=0507 with BLANK_LZ=1 -> 00,6D,3F,07.
//  3. number=9999 -> all 6F, ovf=0. number=10000 -> all 40, ovf=1.
//     number=16383 -> all 40, ovf=1.
//  4. start=1 at E0, number changed and start pulsed at E5 -> second start ignored;
//     the first value is displayed at E15; busy=0 after E15.
//  5. rst_n low at E7 of a conversion -> busy, done and ovf drop immediately;
//     ss=00; no done pulse follows release.
//  6. start held high with number stepping 0..20 -> done every 16 clk; each
//     display matches the number captured at its start edge.

Source files
------------

// File: rtl/bcd_display_driver_pkg.sv
// ============================================================================
// Module  : alu_disp_pkg
// Brief   : Shared types and 7-segment constants for the display driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  // Segment order {dp,g,f,e,d,c,b,a}, decimal point always off.
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_display_driver_if.sv
// ============================================================================
// Module  : bcd_display_driver_if
// Brief   : Request/display bundle between the datapath and the display driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_driver_if #(
  parameter int WIDTH = 14
);

  logic [WIDTH-1:0] number;
  logic             start;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [7:0]       ss3;
  logic [7:0]       ss2;
  logic [7:0]       ss1;
  logic [7:0]       ss0;

  modport master (
    output number, start,
    input  busy, done, ovf, ss3, ss2, ss1, ss0
  );

  modport slave (
    input  number, start,
    output busy, done, ovf, ss3, ss2, ss1, ss0
  );

endinterface

`default_nettype wire

// File: rtl/bcd_display_driver_seg7.sv
// ============================================================================
// Module  : seg7_digit
// Brief   : Combinational BCD digit to 7-segment encoder with blank control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_digit
  import alu_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Non-decimal nibbles fall through to blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      for (int k = 0; k < 10; k++) begin
        if (bcd_i == 4'(k)) begin
          seg_o = SEG_DIGIT[k];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_driver.sv
// ============================================================================
// Module  : bcd_display_driver
// Brief   : Serial binary-to-BCD conversion with registered 7-segment outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_driver
  import alu_disp_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int NDIG     = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_display_driver_if.slave  bus
);

  localparam int BCD_W = 4 * (NDIG + 1);
  localparam int CNT_W = $clog2(WIDTH);

  disp_state_t      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             ovf_q;
  logic [7:0]       seg_q [NDIG];

  logic [4*NDIG-1:0] w_bcd_adj;
  logic [NDIG-1:0]   w_blank;
  logic              w_lead_zero;
  logic              w_ovf;
  logic [7:0]        w_seg_raw [NDIG];
  logic [7:0]        w_seg     [NDIG];

  // Only the displayed digits need the add-3 step; the overflow digit stays
  // below 5 for any 14-bit input and just collects shifted-out carries.
  always_comb begin
    w_bcd_adj = bcd_q[4*NDIG-1:0];
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.number;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_q[BCD_W-2 -: 3], w_bcd_adj, bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_ovf = |bcd_q[BCD_W-1 -: 4];

  // A digit blanks only while it and every digit above it are zero.
  always_comb begin
    w_blank     = '0;
    w_lead_zero = 1'b1;
    if (BLANK_LZ != 0) begin
      for (int k = NDIG - 1; k >= 1; k--) begin
        w_lead_zero = w_lead_zero && (bcd_q[4*k +: 4] == 4'd0);
        w_blank[k]  = w_lead_zero;
      end
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    seg7_digit u_seg7 (
      .bcd_i   (bcd_q[4*g +: 4]),
      .blank_i (w_blank[g]),
      .seg_o   (w_seg_raw[g])
    );
    assign w_seg[g] = w_ovf ? SEG_DASH : w_seg_raw[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        seg_q[k] <= SEG_BLANK;
      end
    end else begin
      done_q <= (state_q == UPDATE);
      if (state_q == UPDATE) begin
        ovf_q <= w_ovf;
        for (int k = 0; k < NDIG; k++) begin
          seg_q[k] <= w_seg[k];
        end
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.ss3  = seg_q[3];
  assign bus.ss2  = seg_q[2];
  assign bus.ss1  = seg_q[1];
  assign bus.ss0  = seg_q[0];

endmodule

`default_nettype wire
